// File: rtl/dff_bank_wr_arbiter.sv
// Round-robin write arbiter in front of a bank of enabled flip-flop registers.
// One write is accepted per cycle; a lock holds ownership and a flush zeroes the whole bank.
module dff_bank_wr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]  data_i,
  input  logic                      flush_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [DEPTH-1:0]          en_o,
  output logic [WIDTH-1:0]          d_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam logic [0:0] StArb    = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [DEPTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic             owner_req;
  logic             sel_valid;
  logic [PTR_W-1:0] sel_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_lock;

  // Two passes: first requester at or above the pointer, else wrap to the lowest one.
  always_comb begin : p_rr
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_valid && req_i[k] && (k >= 32'(ptr_q))) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_valid && req_i[k]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(k);
      end
    end
  end

  assign owner_req = |(req_i & (NUM_REQ'(1) << owner_q));

  always_comb begin : p_sel
    sel_valid = 1'b0;
    sel_idx   = win_idx;
    if (!reset && !flush_i) begin
      if (state_q == StLocked) begin
        sel_idx   = owner_q;
        sel_valid = owner_req;
      end else begin
        sel_valid = win_valid;
      end
    end
  end

  always_comb begin : p_mux
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(sel_idx) == k) begin
        sel_addr = addr_i[k*ADDR_W +: ADDR_W];
        sel_data = data_i[k*WIDTH +: WIDTH];
        sel_lock = lock_i[k];
      end
    end
  end

  assign gnt_o = sel_valid ? (NUM_REQ'(1) << sel_idx) : '0;

  always_comb begin : p_next
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    en_d    = '0;
    d_d     = d_q;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    if (flush_i) begin
      state_d = StArb;
      en_d    = '1;
      d_d     = '0;
    end else if (sel_valid) begin
      ptr_d   = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
      owner_d = sel_idx;
      state_d = sel_lock ? StLocked : StArb;
      busy_d  = sel_lock;
      d_d     = sel_data;
      // Out-of-range targets still consume the slot but enable nothing.
      if (32'(sel_addr) < DEPTH) begin
        en_d = DEPTH'(1) << sel_addr;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      state_d = StArb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StArb;
      ptr_q   <= '0;
      owner_q <= '0;
      en_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign en_o   = en_q;
  assign d_o    = d_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dff_bank_wr_arbiter.sv
// Bench for dff_bank_wr_arbiter: directed vector table on a 4x4 and a 5x5 instance,
// then random traffic on the 4x4 instance against a behavioural model.
module tb_dff_bank_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset4 = 1'b1, flush4 = 1'b0;
  logic [3:0]  req4 = '0, lock4 = '0, gnt4, en4;
  logic [7:0]  addr4 = '0;
  logic [31:0] data4 = '0;
  logic [7:0]  d4;
  logic        busy4, err4;

  logic        reset5 = 1'b1, flush5 = 1'b0;
  logic [4:0]  req5 = '0, lock5 = '0, gnt5, en5;
  logic [14:0] addr5 = '0;
  logic [39:0] data5 = '0;
  logic [7:0]  d5;
  logic        busy5, err5;

  dff_bank_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset4), .req_i(req4), .lock_i(lock4), .addr_i(addr4),
    .data_i(data4), .flush_i(flush4), .gnt_o(gnt4), .en_o(en4), .d_o(d4),
    .busy_o(busy4), .err_o(err4)
  );

  dff_bank_wr_arbiter #(.NUM_REQ(5), .WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .reset(reset5), .req_i(req5), .lock_i(lock5), .addr_i(addr5),
    .data_i(data5), .flush_i(flush5), .gnt_o(gnt5), .en_o(en5), .d_o(d5),
    .busy_o(busy5), .err_o(err5)
  );

  // Register bank fed by the 4x4 instance.
  logic [7:0] bank4 [4];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (en4[i]) bank4[i] <= d4;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          d5;
    bit          rst;
    bit          fl;
    logic [4:0]  req;
    logic [4:0]  lock;
    logic [14:0] addr;
    logic [39:0] data;
    logic [4:0]  gnt;
    logic [4:0]  en;
    logic [7:0]  d;
    bit          busy;
    bit          err;
    int          bidx;
    logic [7:0]  bval;
  } vec_t;

  function automatic vec_t mk(input bit d5, input bit rst, input bit fl, input logic [4:0] req,
                              input logic [4:0] lock, input logic [14:0] addr,
                              input logic [39:0] data, input logic [4:0] gnt,
                              input logic [4:0] en, input logic [7:0] d, input bit busy,
                              input bit err, input int bidx = -1, input logic [7:0] bval = 8'h0);
    vec_t v;
    v.d5 = d5; v.rst = rst; v.fl = fl; v.req = req; v.lock = lock; v.addr = addr;
    v.data = data; v.gnt = gnt; v.en = en; v.d = d; v.busy = busy; v.err = err;
    v.bidx = bidx; v.bval = bval;
    return v;
  endfunction

  task automatic apply(input int row, input vec_t t);
    if (t.d5) begin
      reset5 = t.rst; flush5 = t.fl; req5 = t.req; lock5 = t.lock;
      addr5 = t.addr; data5 = t.data;
    end else begin
      reset4 = t.rst; flush4 = t.fl; req4 = t.req[3:0]; lock4 = t.lock[3:0];
      addr4 = t.addr[7:0]; data4 = t.data[31:0];
    end
    #1;
    chk($sformatf("row%0d gnt", row), t.d5 ? {35'b0, gnt5} : {36'b0, gnt4}, {35'b0, t.gnt});
    @(posedge clk);
    #1;
    chk($sformatf("row%0d en", row), t.d5 ? {35'b0, en5} : {36'b0, en4}, {35'b0, t.en});
    chk($sformatf("row%0d d", row), t.d5 ? {32'b0, d5} : {32'b0, d4}, {32'b0, t.d});
    chk($sformatf("row%0d busy", row), t.d5 ? busy5 : busy4, t.busy);
    chk($sformatf("row%0d err", row), t.d5 ? err5 : err4, t.err);
    if (t.bidx >= 0) chk($sformatf("row%0d bank", row), bank4[t.bidx], t.bval);
  endtask

  vec_t vecs[$];

  // Random-phase state.
  bit         pend [4];
  logic [1:0] paddr [4];
  logic [7:0] pdata [4];
  int         m_ptr, m_owner, g;
  bit         m_locked, m_busy, m_err, rst, fl;
  logic [3:0] m_en, exp_g, lk;
  logic [7:0] m_d;

  initial begin
    // 4x4 instance: {d5, rst, fl, req, lock, addr, data} -> {gnt, en, d, busy, err}
    vecs.push_back(mk(0, 1, 0, 5'b0000, 5'b0, 15'h00, 40'h0, 5'b0000, 5'b0000, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0001, 5'b0, 15'h02, 40'hA5, 5'b0001, 5'b0100, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0000, 5'b0, 15'h00, 40'h0, 5'b0000, 5'b0000, 8'hA5, 0, 0,
                      2, 8'hA5));
    vecs.push_back(mk(0, 1, 0, 5'b0000, 5'b0, 15'h00, 40'h0, 5'b0000, 5'b0000, 8'h00, 0, 0));
    for (int r = 0; r < 8; r++) begin
      logic [4:0] oh;
      logic [7:0] dv;
      oh = 5'(1 << (r % 4));
      dv = 8'(8'h11 * ((r % 4) + 1));
      vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0, 15'hE4, 40'h44332211, oh, oh, dv, 0, 0));
    end
    // Lock by requester 2, three more owner writes, release on the last.
    vecs.push_back(mk(0, 0, 0, 5'b0100, 5'b0100, 15'hE4, 40'h44332211, 5'b0100, 5'b0100, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0100, 15'hE4, 40'h44332211, 5'b0100, 5'b0100, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0100, 15'hE4, 40'h44332211, 5'b0100, 5'b0100, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0000, 15'hE4, 40'h44332211, 5'b0100, 5'b0100, 8'h33, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0000, 15'hE4, 40'h44332211, 5'b1000, 5'b1000, 8'h44, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0000, 15'hE4, 40'h44332211, 5'b0001, 5'b0001, 8'h11, 0, 0));
    // Flush beats requests, repeats back to back, and clears a lock.
    vecs.push_back(mk(0, 1, 0, 5'b0000, 5'b0, 15'hE4, 40'h44332211, 5'b0000, 5'b0000, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5'b0011, 5'b0, 15'hE4, 40'h44332211, 5'b0000, 5'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0011, 5'b0, 15'hE4, 40'h44332211, 5'b0001, 5'b0001, 8'h11, 0, 0,
                      3, 8'h00));
    vecs.push_back(mk(0, 0, 1, 5'b0011, 5'b0, 15'hE4, 40'h44332211, 5'b0000, 5'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5'b0011, 5'b0, 15'hE4, 40'h44332211, 5'b0000, 5'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0011, 5'b0, 15'hE4, 40'h44332211, 5'b0010, 5'b0010, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0001, 5'b0001, 15'hE4, 40'h44332211, 5'b0001, 5'b0001, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 1, 5'b0011, 5'b0001, 15'hE4, 40'h44332211, 5'b0000, 5'b1111, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b0011, 5'b0000, 15'hE4, 40'h44332211, 5'b0010, 5'b0010, 8'h22, 0, 0));
    // Reset while requester 1 holds the lock.
    vecs.push_back(mk(0, 0, 0, 5'b0010, 5'b0010, 15'hE4, 40'h44332211, 5'b0010, 5'b0010, 8'h22, 1, 0));
    vecs.push_back(mk(0, 1, 0, 5'b0010, 5'b0010, 15'hE4, 40'h44332211, 5'b0000, 5'b0000, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1111, 5'b0000, 15'hE4, 40'h44332211, 5'b0001, 5'b0001, 8'h11, 0, 0));
    // Owner drops its request: release with no grant, d_o holds.
    vecs.push_back(mk(0, 0, 0, 5'b0100, 5'b0100, 15'hE4, 40'h44332211, 5'b0100, 5'b0100, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1011, 5'b0000, 15'hE4, 40'h44332211, 5'b0000, 5'b0000, 8'h33, 0, 0));
    vecs.push_back(mk(0, 0, 0, 5'b1011, 5'b0000, 15'hE4, 40'h44332211, 5'b1000, 5'b1000, 8'h44, 0, 0));
    // 5x5 instance: out-of-range addresses.
    vecs.push_back(mk(1, 1, 0, 5'b00000, 5'b0, 15'h0000, 40'h0, 5'b00000, 5'b00000, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5'b00001, 5'b0, 15'h0006, 40'h5A, 5'b00001, 5'b00000, 8'h5A, 0, 1));
    vecs.push_back(mk(1, 0, 0, 5'b00011, 5'b0, 15'h000C, 40'h3CC3, 5'b00010, 5'b00010, 8'h3C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5'b00000, 5'b0, 15'h0000, 40'h0, 5'b00000, 5'b00000, 8'h3C, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5'b10000, 5'b10000, 15'h7000, 40'h7700000000, 5'b10000, 5'b00000,
                      8'h77, 1, 1));
    vecs.push_back(mk(1, 0, 0, 5'b10001, 5'b00000, 15'h5000, 40'h7800000000, 5'b10000, 5'b00000,
                      8'h78, 0, 1));
    vecs.push_back(mk(1, 0, 0, 5'b00001, 5'b00000, 15'h0004, 40'h99, 5'b00001, 5'b10000, 8'h99, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Random traffic; requests stay up with stable addr/data until granted.
    m_ptr = 0; m_owner = 0; m_locked = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]  = 1'b1;
          paddr[k] = 2'($urandom);
          pdata[k] = 8'($urandom);
        end
        lk[k]            = ($urandom_range(0, 2) == 0);
        req4[k]          = pend[k];
        addr4[2*k +: 2]  = paddr[k];
        data4[8*k +: 8]  = pdata[k];
      end
      reset4 = rst; flush4 = fl; lock4 = lk;
      #1;
      g = -1;
      if (!rst && !fl) begin
        if (m_locked) begin
          if (pend[m_owner]) g = m_owner;
        end else begin
          for (int i = 0; i < 4; i++) if (g < 0 && pend[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        end
      end
      exp_g = (g < 0) ? 4'b0000 : 4'(1 << g);
      chk("rnd gnt", {36'b0, gnt4}, {36'b0, exp_g});
      if (rst) begin
        m_ptr = 0; m_locked = 0; m_en = '0; m_d = '0; m_busy = 0; m_err = 0;
      end else if (fl) begin
        m_locked = 0; m_en = 4'b1111; m_d = '0; m_busy = 0; m_err = 0;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % 4; m_owner = g; m_locked = lk[g]; m_busy = lk[g];
        m_en = 4'(1 << paddr[g]); m_d = pdata[g]; m_err = 0;
      end else begin
        m_locked = 0; m_en = '0; m_busy = 0; m_err = 0;
      end
      @(posedge clk);
      #1;
      chk("rnd en", {36'b0, en4}, {36'b0, m_en});
      chk("rnd d", {32'b0, d4}, {32'b0, m_d});
      chk("rnd busy", busy4, m_busy);
      chk("rnd err", err4, m_err);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
